// File: rtl/trigger_out_shaper.sv
// rtl/trigger_out_shaper.sv - trigger pulse shaper: delay/width/holdoff with event and missed-event counters
// Optional TRIG_OUT_TIMESTAMP_EN adds a free-running timestamp captured on accepted edges.
module trigger_out_shaper #(
  parameter int CNT_WIDTH = 24,
  parameter int EVT_WIDTH = 16
) (
  input  logic                 adc_clk,
  input  logic                 trig_reset_n,
  input  logic                 trig_in,
  input  logic [1:0]           cfg_addr,
  input  logic                 cfg_wrt,
  input  logic [CNT_WIDTH-1:0] cfg_data,
  output logic                 trig_out,
  output logic                 busy,
  output logic [EVT_WIDTH-1:0] event_count,
  output logic [EVT_WIDTH-1:0] missed_count,
  output logic [31:0]          trig_timestamp
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DELAY   = 2'd1,
    ACTIVE  = 2'd2,
    HOLDOFF = 2'd3
  } state_t;

  localparam logic [CNT_WIDTH-1:0] ONE     = CNT_WIDTH'(1);
  localparam logic [EVT_WIDTH-1:0] EVT_MAX = '1;

  state_t               state, state_n;
  logic                 trig_in_d, rise, accept, miss;
  logic                 trig_out_n;
  logic [CNT_WIDTH-1:0] delay_reg, width_reg, holdoff_reg;
  logic [CNT_WIDTH-1:0] sh_width, sh_holdoff;
  logic [CNT_WIDTH-1:0] cnt, cnt_n;

  assign rise   = trig_in & ~trig_in_d;
  assign accept = rise && (state == IDLE);
  assign miss   = rise && (state != IDLE);

  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    trig_out_n = trig_out;
    case (state)
      IDLE: begin
        // Zero delay fires on the capture edge itself; width_reg is what the shadow latches now.
        if (rise) begin
          if (delay_reg == '0) begin
            state_n    = ACTIVE;
            trig_out_n = 1'b1;
            cnt_n      = width_reg;
          end else begin
            state_n = DELAY;
            cnt_n   = delay_reg;
          end
        end
      end
      DELAY: begin
        cnt_n = cnt - ONE;
        if (cnt == ONE) begin
          state_n    = ACTIVE;
          trig_out_n = 1'b1;
          cnt_n      = sh_width;
        end
      end
      ACTIVE: begin
        cnt_n = cnt - ONE;
        if (cnt == ONE) begin
          trig_out_n = 1'b0;
          if (sh_holdoff == '0) begin
            state_n = IDLE;
          end else begin
            state_n = HOLDOFF;
            cnt_n   = sh_holdoff;
          end
        end
      end
      HOLDOFF: begin
        cnt_n = cnt - ONE;
        if (cnt == ONE) state_n = IDLE;
      end
      default: begin
        state_n    = IDLE;
        trig_out_n = 1'b0;
        cnt_n      = '0;
      end
    endcase
  end

  always_ff @(posedge adc_clk or negedge trig_reset_n) begin
    if (!trig_reset_n) begin
      state    <= IDLE;
      busy     <= 1'b0;
      trig_out <= 1'b0;
      cnt      <= '0;
    end else begin
      state    <= state_n;
      busy     <= (state_n != IDLE);
      trig_out <= trig_out_n;
      cnt      <= cnt_n;
    end
  end

  always_ff @(posedge adc_clk or negedge trig_reset_n) begin
    if (!trig_reset_n) begin
      trig_in_d    <= 1'b0;
      delay_reg    <= '0;
      width_reg    <= ONE;
      holdoff_reg  <= '0;
      sh_width     <= ONE;
      sh_holdoff   <= '0;
      event_count  <= '0;
      missed_count <= '0;
    end else begin
      trig_in_d <= trig_in;
      if (cfg_wrt) begin
        case (cfg_addr)
          2'd0:    delay_reg   <= cfg_data;
          2'd1:    width_reg   <= (cfg_data == '0) ? ONE : cfg_data;
          2'd2:    holdoff_reg <= cfg_data;
          default: ;
        endcase
      end
      // Shadows take the pre-write values, so a same-cycle write lands on the next event.
      if (accept) begin
        sh_width   <= width_reg;
        sh_holdoff <= holdoff_reg;
        if (event_count != EVT_MAX) event_count <= event_count + 1'b1;
      end
      if (miss && (missed_count != EVT_MAX)) missed_count <= missed_count + 1'b1;
    end
  end

`ifdef TRIG_OUT_TIMESTAMP_EN
  logic [31:0] ts_cnt;

  always_ff @(posedge adc_clk or negedge trig_reset_n) begin
    if (!trig_reset_n) begin
      ts_cnt         <= '0;
      trig_timestamp <= '0;
    end else begin
      ts_cnt <= ts_cnt + 32'd1;
      if (accept) trig_timestamp <= ts_cnt;
    end
  end
`else
  assign trig_timestamp = '0;
`endif

endmodule

// File: tb/tb_trigger_out_shaper.sv
// tb/tb_trigger_out_shaper.sv - directed self-checking bench for trigger_out_shaper
module tb_trigger_out_shaper;

  logic        adc_clk;
  logic        trig_reset_n;
  logic        trig_in;
  logic [1:0]  cfg_addr;
  logic        cfg_wrt;
  logic [23:0] cfg_data;
  logic        trig_out;
  logic        busy;
  logic [15:0] event_count;
  logic [15:0] missed_count;
  logic [31:0] trig_timestamp;

  int vectors    = 0;
  int miscompares = 0;
  int cycles     = 0;

  trigger_out_shaper #(.CNT_WIDTH(24), .EVT_WIDTH(16)) dut (
    .adc_clk        (adc_clk),
    .trig_reset_n   (trig_reset_n),
    .trig_in        (trig_in),
    .cfg_addr       (cfg_addr),
    .cfg_wrt        (cfg_wrt),
    .cfg_data       (cfg_data),
    .trig_out       (trig_out),
    .busy           (busy),
    .event_count    (event_count),
    .missed_count   (missed_count),
    .trig_timestamp (trig_timestamp)
  );

  initial adc_clk = 1'b0;
  always #5 adc_clk = ~adc_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge adc_clk);
    cycles++;
    @(negedge adc_clk);
  endtask

  task automatic do_reset();
    trig_reset_n = 1'b0;
    @(posedge adc_clk);
    @(negedge adc_clk);
    trig_reset_n = 1'b1;
    cycles = 0;
  endtask

  task automatic set_cfg(input logic [1:0] a, input logic [23:0] d);
    cfg_addr = a;
    cfg_data = d;
    cfg_wrt  = 1'b1;
    step();
    cfg_wrt  = 1'b0;
  endtask

  task automatic run_event(input bit wr_mid, input logic [23:0] wdata, output int len);
    trig_in = 1'b1;
    step();
    trig_in = 1'b0;
    len = int'(trig_out);
    for (int i = 1; i < 30; i++) begin
      if (wr_mid && i == 1) begin
        cfg_addr = 2'd1;
        cfg_data = wdata;
        cfg_wrt  = 1'b1;
      end
      step();
      cfg_wrt = 1'b0;
      len += int'(trig_out);
    end
  endtask

  initial begin
    int cap;
    int len;
    int pulses;
    logic prev;

    trig_reset_n = 1'b0;
    trig_in      = 1'b0;
    cfg_addr     = 2'd0;
    cfg_wrt      = 1'b0;
    cfg_data     = '0;
    repeat (2) @(negedge adc_clk);
    chk("rst_trig_out", trig_out, 0);
    chk("rst_busy", busy, 0);
    chk("rst_event", event_count, 0);
    chk("rst_missed", missed_count, 0);
    chk("rst_ts", trig_timestamp, 0);
    trig_reset_n = 1'b1;
    cycles = 0;

    // Defaults (delay 0, width 1, holdoff 0); rise captured on posedge 500 after release
    repeat (500) step();
    trig_in = 1'b1;
    step();
    trig_in = 1'b0;
    chk("t1_trig_out_hi", trig_out, 1);
    chk("t1_busy_hi", busy, 1);
    chk("t1_event", event_count, 1);
`ifdef TRIG_OUT_TIMESTAMP_EN
    chk("t1_ts", trig_timestamp, 500);
`else
    chk("t1_ts", trig_timestamp, 0);
`endif
    step();
    chk("t1_trig_out_lo", trig_out, 0);
    chk("t1_busy_lo", busy, 0);

    // delay 10, width 4, holdoff 0: pulse on offsets 10..13, busy 0..13
    set_cfg(2'd0, 24'd10);
    set_cfg(2'd1, 24'd4);
    set_cfg(2'd2, 24'd0);
    trig_in = 1'b1;
    step();
    trig_in = 1'b0;
    chk("t2_busy_0", busy, 1);
    chk("t2_out_0", trig_out, 0);
    for (int off = 1; off <= 15; off++) begin
      step();
      chk($sformatf("t2_out_%0d", off), trig_out, (off >= 10 && off <= 13) ? 1 : 0);
      chk($sformatf("t2_busy_%0d", off), busy, (off <= 13) ? 1 : 0);
    end
    chk("t2_event", event_count, 2);

    // delay 2, width 3, holdoff 20: rises at offsets 5 (missed), 26 (ok), 51 (missed on return), 53 (ok)
    do_reset();
    set_cfg(2'd0, 24'd2);
    set_cfg(2'd1, 24'd3);
    set_cfg(2'd2, 24'd20);
    cap = cycles;
    trig_in = 1'b1;
    step();
    trig_in = 1'b0;
    for (int off = 1; off <= 53; off++) begin
      trig_in = (off == 5 || off == 26 || off == 51 || off == 53);
      step();
      if (off == 5) begin
        chk("t3_missed_5", missed_count, 1);
        chk("t3_event_5", event_count, 1);
`ifdef TRIG_OUT_TIMESTAMP_EN
        chk("t3_ts_after_miss", trig_timestamp, cap);
`else
        chk("t3_ts_after_miss", trig_timestamp, 0);
`endif
      end
      if (off == 3) chk("t3_out_3", trig_out, 1);
      if (off == 5) chk("t3_out_5", trig_out, 0);
      if (off == 24) chk("t3_busy_24", busy, 1);
      if (off == 25) chk("t3_busy_25", busy, 0);
      if (off == 26) chk("t3_event_26", event_count, 2);
      if (off == 51) chk("t3_busy_51", busy, 0);
    end
    trig_in = 1'b0;
    chk("t3_event_end", event_count, 3);
    chk("t3_missed_end", missed_count, 2);
    chk("t3_busy_end", busy, 1);

    // Width rewrite mid-pulse affects only the next event; width 0 stores 1
    do_reset();
    set_cfg(2'd1, 24'd3);
    run_event(1'b1, 24'd8, len);
    chk("t4_len_cur", len, 3);
    run_event(1'b0, 24'd0, len);
    chk("t4_len_next", len, 8);
    set_cfg(2'd1, 24'd0);
    run_event(1'b0, 24'd0, len);
    chk("t4_len_w0", len, 1);

    // Level held high 1000 cycles with all registers written 0
    do_reset();
    set_cfg(2'd0, 24'd0);
    set_cfg(2'd1, 24'd0);
    set_cfg(2'd2, 24'd0);
    pulses = 0;
    prev = 1'b0;
    trig_in = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      step();
      if (trig_out && !prev) pulses++;
      prev = trig_out;
    end
    trig_in = 1'b0;
    step();
    chk("t5_pulses", pulses, 1);
    chk("t5_event", event_count, 1);
    chk("t5_missed", missed_count, 0);

    // Asynchronous reset while ACTIVE
    set_cfg(2'd1, 24'd50);
    trig_in = 1'b1;
    step();
    trig_in = 1'b0;
    repeat (5) step();
    chk("t6_active", trig_out, 1);
    #2 trig_reset_n = 1'b0;
    #1;
    chk("t6_trig_out", trig_out, 0);
    chk("t6_busy", busy, 0);
    chk("t6_event", event_count, 0);
    chk("t6_missed", missed_count, 0);
    chk("t6_ts", trig_timestamp, 0);
    @(negedge adc_clk);
    trig_reset_n = 1'b1;
    step();
    chk("t6_idle_after", busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
